// File: rtl/cla_seq_adder_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// cla_seq_pkg : shared state type, default sizes and helpers for the sequential
//               carry-lookahead adder controller.                    Rev 1.0
// -----------------------------------------------------------------------------
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 64;
    localparam int CHUNK_DEF = 16;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice counter never collapses to zero bits, even for a single slice.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// cla_seq_adder_ctrl_if : request/result valid-ready bundle of the sequential
//                         adder controller.                          Rev 1.0
// -----------------------------------------------------------------------------
interface cla_seq_adder_ctrl_if
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum_out, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, cin, op_sub, out_ready,
        output in_ready, out_valid, sum_out, cout, ovf, busy
    );

endinterface
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_slice.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// cla_add_slice : CHUNK-bit adder from 4-bit lookahead groups with a second
//                 lookahead level across the groups.                 Rev 1.0
// -----------------------------------------------------------------------------
module cla_add_slice
    import cla_seq_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    localparam int NGRP = CHUNK / 4;

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_c;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP:0]    w_cg;

    assign w_g = a & b;
    assign w_p = a ^ b;

    generate
        for (genvar k = 0; k < NGRP; k++) begin : g_grp
            localparam int B = 4 * k;

            assign w_c[B]   = w_cg[k];
            assign w_c[B+1] = w_g[B] | (w_p[B] & w_cg[k]);
            assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_cg[k]);
            assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_cg[k]);

            assign w_gg[k] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                           | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                           | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
            assign w_gp[k] = &w_p[B+3:B];
        end
    endgenerate

    // Each group carry is a flat sum-of-products of group G/P and ci, not a chain.
    always_comb begin
        logic v_term;
        v_term  = 1'b0;
        w_cg    = '0;
        w_cg[0] = ci;
        for (int k = 1; k <= NGRP; k++) begin
            v_term = ci;
            for (int j = 0; j < k; j++) begin
                v_term = v_term & w_gp[j];
            end
            w_cg[k] = v_term;
            for (int j = 0; j < k; j++) begin
                v_term = w_gg[j];
                for (int m = j + 1; m < k; m++) begin
                    v_term = v_term & w_gp[m];
                end
                w_cg[k] = w_cg[k] | v_term;
            end
        end
    end

    assign s     = w_p ^ w_c;
    assign co    = w_cg[NGRP];
    assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// cla_seq_adder_ctrl : runs a WIDTH-bit add/subtract through one CHUNK-bit
//                      lookahead slice, one slice per cycle.         Rev 1.0
// -----------------------------------------------------------------------------
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_seq_adder_ctrl_if.slave  bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cout;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;

    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;

    cla_add_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (r_a[CHUNK-1:0]),
        .b     (r_b[CHUNK-1:0]),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
            RUN:     if (r_cnt == LAST) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
            end
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST);

    generate
        if (NCHUNK == 1) begin : g_res_single
            assign w_res_nxt = w_s;
        end else begin : g_res_shift
            assign w_res_nxt = {w_s, r_res[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Subtraction is folded in at accept time: B is stored inverted with carry 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a_in;
            r_b     <= bus.op_sub ? ~bus.b_in : bus.b_in;
            r_carry <= bus.op_sub | bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_res   <= w_res_nxt;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_c_msb ^ w_co;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum_out   = r_res;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Sequencer that runs wide add/subtract operations through one narrow carry-lookahead adder slice, processing one CHUNK-bit slice per cycle and keeping the carry in a register between slices. It sits between the perceptron accumulate path and the shared adder slice. It provides a valid/ready request side and a valid/ready result side. The block trades latency for area: a WIDTH-bit add costs WIDTH/CHUNK cycles on one CHUNK-bit lookahead adder.

## Interface
Parameters:
- WIDTH, 64, operand and result width; must be a multiple of CHUNK
- CHUNK, 16, slice width per cycle; must be a multiple of 4 (built from 4-bit lookahead groups)

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when op_sub=1
- op_sub  input  1  1: A-B (B inverted, carry-in forced 1); 0: A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow
- busy  output  1  state is not IDLE

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a_in into register A. Latch b_in into register B, inverted if op_sub=1.
  - Set carry register to (op_sub ? 1 : cin). Clear slice counter cnt to 0. Go to RUN.
- RUN:
  - Slice input is A[CHUNK-1:0], B[CHUNK-1:0] and the carry register.
  - Each cycle:
    - Shift A and B right by CHUNK.
    - Shift the slice sum into the top of the result register (result right-shifted by CHUNK).
    - Update carry register with the slice carry-out. Increment cnt.
  - When cnt==NCHUNK-1 (NCHUNK=WIDTH/CHUNK), the slice of that cycle is the last one:
    - Capture cout = slice carry-out.
    - Capture ovf = slice carry into its MSB XOR slice carry-out.
    - Go to DONE.
- DONE:
  - out_valid=1, and sum_out/cout/ovf are held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE.
- in_ready is 1 only in IDLE. There is no accept in the DONE→IDLE handoff cycle; the next request is accepted earliest the cycle after.
- in_valid is ignored outside IDLE. Operand inputs are sampled only at the accept edge, so later changes have no effect.
- Arithmetic:
  - Modulo 2^WIDTH.
  - cout is the unsigned carry; for subtract, cout=1 means no borrow (A≥B unsigned).
  - ovf=1 iff the signed result is out of range.
- cnt width is $clog2(NCHUNK), minimum 1. When NCHUNK==1, RUN lasts exactly one cycle.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0, carry=0.
  - sum_out=0, cout=0, ovf=0, out_valid=0, busy=0; in_ready=1 after release.
  - Reset takes priority over any handshake in the same cycle.
  - Reset mid-RUN or mid-DONE discards the operation with no output.
- Latency: accept at the edge ending cycle t. RUN occupies cycles t+1..t+NCHUNK. out_valid=1 from cycle t+NCHUNK+1.
- Defaults: NCHUNK=4, so out_valid appears 5 cycles after accept.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- out_ready stall: DONE persists indefinitely with outputs frozen.
- Outputs are registered, with no combinational in→out paths. in_ready and out_valid are decoded from the state register.
- Critical path is one CHUNK-bit lookahead add plus the carry register.

## Structure
- Package cla_seq_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default constants WIDTH_DEF=64 and CHUNK_DEF=16;
  - the function computing NCHUNK.
- Sub-module cla_add_slice (parameter CHUNK):
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into the slice MSB, used for ovf).
  - Built as two-level 4-bit lookahead groups.
- The controller holds the FSM, the counter, the shift registers and the result register.

## Test plan
- Reset mid-RUN: accept an operation, assert rst_n=0 in the 2nd RUN cycle → next cycle busy=0, out_valid=0, sum_out=0; a new request is accepted right after release.
- Full carry ripple across slices:
  - Stimulus: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, cin=0, op_sub=0.
  - Expected: out_valid at accept+5, sum_out=0, cout=1, ovf=0.
- Signed overflow:
  - Stimulus: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, add.
  - Expected: sum_out=64'h8000_0000_0000_0000, cout=0, ovf=1.
- Subtract:
  - Stimulus 1: A=5, B=7, op_sub=1, cin=1 (ignored).
  - Expected 1: sum_out=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - Stimulus 2: A=7, B=5.
  - Expected 2: sum_out=2, cout=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands.
  - Expected: outputs stable, in_ready=0, no new operation accepted; after out_ready=1, IDLE next cycle, then accept.
- Back-to-back random:
  - Stimulus: 1000 random add/sub with random out_ready.
  - Expected: every result matches a reference model; accept-to-valid latency is always exactly 5 cycles.
